jtag_ahb_ap_dr: RTL and testbench

//  Parametrised AHB access-port data register for the JTAG AHB instruction.

---
 rtl/jtag_types_pkg.sv | 53 +++++
 rtl/ahb_ap_master.sv | 118 +++++++++++
 rtl/jtag_ahb_ap_dr.sv | 142 ++++++++++++++
 tb/tb_jtag_ahb_ap_dr.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// ----------------------------------------------------------------------------
// jtag_types_pkg
// Shared types for the JTAG debug blocks. Holds the scan-frame field
// encodings (regselect_t, hsize_t, r_w_t) and the AHB access-port
// additions: FSM state encoding, status word layout and capture marker.
// No ports; imported by jtag_ahb_ap_dr and ahb_ap_master.
// ----------------------------------------------------------------------------
package jtag_types_pkg;

    typedef enum logic {
        REG_ADDRESS = 1'b0,
        REG_DATA    = 1'b1
    } regselect_t;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'b00,
        HSIZE_HALF = 2'b01,
        HSIZE_WORD = 2'b10,
        HSIZE_RSVD = 2'b11
    } hsize_t;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } r_w_t;

    // AP master FSM states, kept as plain constants so older tools that
    // dislike enum-typed state registers still read them.
    typedef logic [1:0] ap_state_t;
    localparam ap_state_t AP_IDLE = 2'd0;
    localparam ap_state_t AP_ADDR = 2'd1;
    localparam ap_state_t AP_DATA = 2'd2;
    localparam ap_state_t AP_ERR  = 2'd3;

    // Low five bits of the capture frame.
    typedef struct packed {
        logic       busy;
        logic       err;
        logic       ovr;
        logic [1:0] marker;
    } ap_status_t;

    localparam logic [1:0] AP_MARKER = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Byte count of one beat for the given transfer size.
    function automatic logic [3:0] size_to_bytes(input hsize_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ahb_ap_master.sv
// ----------------------------------------------------------------------------
// ahb_ap_master
// Single-transfer AHB-Lite master for the JTAG AHB access port. Owns the
// address register with its auto-increment, the latched size/increment
// settings, the write data and the read-data register.
// Build option: define AHB_AP_WRAP_1K_EN to keep auto-increment inside the
// current 1 KB block (addr[9:0] counts, upper bits held); otherwise the
// address increments over its full width.
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   launch, launch_write,
//   launch_wdata                 start a transfer (only honoured when idle)
//   addr_load, addr_value,
//   size_value, inc_value        load address and transfer settings
//   haddr, htrans, hwrite,
//   hsize, hwdata                AHB-Lite master outputs
//   hrdata, hready, hresp        AHB-Lite slave response
//   busy                         transfer in flight
//   xfer_err                     pulse when an ERROR response completes
//   rdata                        last successfully read data
// ----------------------------------------------------------------------------
module ahb_ap_master
    import jtag_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              launch,
    input  logic              launch_write,
    input  logic [DATA_W-1:0] launch_wdata,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    input  hsize_t            size_value,
    input  logic              inc_value,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              busy,
    output logic              xfer_err,
    output logic [DATA_W-1:0] rdata
);

    ap_state_t         state;
    ap_state_t         state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_inc;
    hsize_t            size_reg;
    logic              inc_reg;
    logic [3:0]        step_bytes;
    logic              ok_done;

    // Next-state logic. hresp in the data phase moves to AP_ERR even while
    // hready is low, so the two-cycle ERROR response is followed.
    always_comb begin
        state_next = state;
        case (state)
            AP_IDLE: if (launch)  state_next = AP_ADDR;
            AP_ADDR: if (hready)  state_next = AP_DATA;
            AP_DATA: begin
                if (hresp)       state_next = AP_ERR;
                else if (hready) state_next = AP_IDLE;
            end
            AP_ERR:  if (hready)  state_next = AP_IDLE;
            default:              state_next = AP_IDLE;
        endcase
    end

    assign ok_done    = (state == AP_DATA) && hready && !hresp;
    assign xfer_err   = (state == AP_ERR) && hready;
    assign step_bytes = size_to_bytes(size_reg);

`ifdef AHB_AP_WRAP_1K_EN
    assign addr_inc = {addr_reg[ADDR_W-1:10], addr_reg[9:0] + 10'(step_bytes)};
`else
    assign addr_inc = addr_reg + ADDR_W'(step_bytes);
`endif

    // State, address and data registers. The address only advances after
    // a clean completion; an ERROR response leaves it in place.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= AP_IDLE;
            addr_reg <= '0;
            size_reg <= HSIZE_BYTE;
            inc_reg  <= 1'b0;
            hwrite   <= 1'b0;
            hwdata   <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (addr_load) begin
                addr_reg <= addr_value;
                size_reg <= size_value;
                inc_reg  <= inc_value;
            end else if (ok_done && inc_reg) begin
                addr_reg <= addr_inc;
            end
            if (launch && (state == AP_IDLE)) begin
                hwrite <= launch_write;
                if (launch_write) hwdata <= launch_wdata;
            end
            if (ok_done && !hwrite) rdata <= hrdata;
        end
    end

    assign haddr  = addr_reg;
    assign htrans = (state == AP_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsize  = {1'b0, size_reg};
    assign busy   = (state != AP_IDLE);

endmodule

// File: rtl/jtag_ahb_ap_dr.sv
// ----------------------------------------------------------------------------
// jtag_ahb_ap_dr
// AHB access-port data register selected by the JTAG AHB instruction.
// Shifts a {data, regselect, size, addrinc, r_w} frame (DATA_W+5 bits,
// LSB out first); update_dr decodes it into an AHB-Lite transfer through
// ahb_ap_master, capture_dr loads {rdata, busy, err, ovr, 2'b01}.
// Build option AHB_AP_WRAP_1K_EN is handled inside ahb_ap_master.
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   ap_sel                       AHB instruction active; gates all strobes
//   capture_dr, shift_dr,
//   update_dr                    one-cycle TAP strobes (synchronised)
//   tdi, tdo                     serial in / out (tdo = shift_reg[0])
//   haddr, htrans, hwrite,
//   hsize, hwdata, hrdata,
//   hready, hresp                AHB-Lite master interface
//   busy                         transfer in flight
// ----------------------------------------------------------------------------
module jtag_ahb_ap_dr
    import jtag_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ap_sel,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic              tdi,
    output logic              tdo,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              busy
);

    localparam int SR_W = DATA_W + 5;

    logic [SR_W-1:0]   shift_reg;
    logic              err_flag;
    logic              ovr_flag;
    logic [DATA_W-1:0] rdata;
    logic              xfer_err;
    ap_status_t        status;

    r_w_t              frame_rw;
    logic              frame_inc;
    hsize_t            frame_size;
    regselect_t        frame_sel;
    logic [DATA_W-1:0] frame_data;

    logic              do_update;
    logic              do_capture;
    logic              do_shift;
    logic              accept;
    logic              reserved;
    logic              addr_load;
    logic              launch;
    logic              launch_write;

    assign frame_rw   = r_w_t'(shift_reg[0]);
    assign frame_inc  = shift_reg[1];
    assign frame_size = hsize_t'(shift_reg[3:2]);
    assign frame_sel  = regselect_t'(shift_reg[4]);
    assign frame_data = shift_reg[SR_W-1:5];

    // Strobes should be one-hot; if not, update wins over capture over shift.
    assign do_update  = ap_sel & update_dr;
    assign do_capture = ap_sel & capture_dr & ~update_dr;
    assign do_shift   = ap_sel & shift_dr & ~update_dr & ~capture_dr;

    // A frame is only acted on when no transfer is in flight; a reserved
    // size rejects the whole frame and only raises err.
    assign accept       = do_update & ~busy;
    assign reserved     = (frame_size == HSIZE_RSVD);
    assign addr_load    = accept & ~reserved & (frame_sel == REG_ADDRESS);
    assign launch       = accept & ~reserved &
                          ((frame_sel == REG_DATA) | (frame_rw == RW_READ));
    assign launch_write = (frame_sel == REG_DATA) & (frame_rw == RW_WRITE);

    always_comb begin
        status.busy   = busy;
        status.err    = err_flag;
        status.ovr    = ovr_flag;
        status.marker = AP_MARKER;
    end

    // Shift register and sticky flags. Sets and clears of err/ovr never
    // coincide: sets happen while busy, the ADDRESS clear only when idle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            shift_reg <= '0;
            err_flag  <= 1'b0;
            ovr_flag  <= 1'b0;
        end else begin
            if (do_capture)    shift_reg <= {rdata, status};
            else if (do_shift) shift_reg <= {tdi, shift_reg[SR_W-1:1]};

            if (do_update && busy) ovr_flag <= 1'b1;
            else if (addr_load)    ovr_flag <= 1'b0;

            if (xfer_err || (accept && reserved)) err_flag <= 1'b1;
            else if (addr_load)                   err_flag <= 1'b0;
        end
    end

    assign tdo = shift_reg[0];

    ahb_ap_master #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_master (
        .CLK          (CLK),
        .nRST         (nRST),
        .launch       (launch),
        .launch_write (launch_write),
        .launch_wdata (frame_data),
        .addr_load    (addr_load),
        .addr_value   (frame_data[ADDR_W-1:0]),
        .size_value   (frame_size),
        .inc_value    (frame_inc),
        .haddr        (haddr),
        .htrans       (htrans),
        .hwrite       (hwrite),
        .hsize        (hsize),
        .hwdata       (hwdata),
        .hrdata       (hrdata),
        .hready       (hready),
        .hresp        (hresp),
        .busy         (busy),
        .xfer_err     (xfer_err),
        .rdata        (rdata)
    );

endmodule

// File: tb/tb_jtag_ahb_ap_dr.sv
// ----------------------------------------------------------------------------
// tb_jtag_ahb_ap_dr
// Directed bench for jtag_ahb_ap_dr. A forked AHB slave inserts wait
// states / ERROR responses and pops expected transfers from a scoreboard
// queue as each NONSEQ is accepted. Honours AHB_AP_WRAP_1K_EN for the
// 1 KB wrap expectation.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtag_ahb_ap_dr;
    import jtag_types_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SR_W   = DATA_W + 5;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ap_sel, capture_dr, shift_dr, update_dr, tdi;
    logic              tdo;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata = '0;
    logic              hready = 1'b1;
    logic              hresp  = 1'b0;
    logic              busy;

    jtag_ahb_ap_dr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .nRST(nRST), .ap_sel(ap_sel), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    xfer_t             exp_q[$];
    int                checks = 0;
    int                passes = 0;
    int                fails  = 0;
    int                nonseq_count = 0;
    logic              stall = 1'b0;
    logic              err_next = 1'b0;
    int                wait_states = 0;
    logic [DATA_W-1:0] rd_value = '0;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [SR_W-1:0] mk(input logic [DATA_W-1:0] data, input logic sel,
                                           input logic [1:0] size, input logic inc,
                                           input logic rw);
        return {data, sel, size, inc, rw};
    endfunction

    task automatic expect_xfer(input logic [ADDR_W-1:0] addr, input logic write,
                               input logic [2:0] size, input logic [DATA_W-1:0] wdata);
        xfer_t x;
        x.addr = addr; x.write = write; x.size = size; x.wdata = wdata;
        exp_q.push_back(x);
    endtask

    // Capture, shift SR_W bits (returning the captured frame), optional update.
    task automatic apply_stimulus(input logic [SR_W-1:0] frame_in, input bit do_update,
                                  output logic [SR_W-1:0] frame_out);
        @(negedge CLK); capture_dr = 1'b1;
        @(negedge CLK); capture_dr = 1'b0;
        for (int i = 0; i < SR_W; i++) begin
            frame_out[i] = tdo;
            tdi          = frame_in[i];
            shift_dr     = 1'b1;
            @(negedge CLK);
        end
        shift_dr = 1'b0;
        if (do_update) begin
            update_dr = 1'b1;
            @(negedge CLK);
            update_dr = 1'b0;
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge CLK);
        end
        check_output("wait_idle_bounded", 64'(cycles < 100), 64'(1));
    endtask

    // AHB slave: decides hready/hresp at each negedge for the next posedge
    // and checks each accepted address phase against the scoreboard.
    task automatic slave_loop();
        logic              in_data, dp_err, err_stage, last_addr, last_ready;
        int                cnt;
        xfer_t             cur;
        logic [ADDR_W-1:0] seen_addr;
        logic              seen_write;
        logic [2:0]        seen_size;
        in_data = 0; dp_err = 0; err_stage = 0; last_addr = 0; last_ready = 0; cnt = 0;
        cur.addr = '0; cur.write = 0; cur.size = '0; cur.wdata = '0;
        seen_addr = '0; seen_write = 0; seen_size = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                in_data = 0; last_addr = 0; last_ready = 0; cnt = 0;
                hready = 1'b1; hresp = 1'b0;
            end else begin
                if (in_data && last_ready) in_data = 0;
                if (last_addr && last_ready) begin
                    nonseq_count++;
                    in_data = 1; cnt = wait_states; dp_err = err_next; err_stage = 0;
                    check_output("sb_expected_nonseq", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check_output("nonseq_haddr", 64'(seen_addr), 64'(cur.addr));
                        check_output("nonseq_hwrite", 64'(seen_write), 64'(cur.write));
                        check_output("nonseq_hsize", 64'(seen_size), 64'(cur.size));
                    end
                end
                hresp = 1'b0;
                if (stall) begin
                    hready = 1'b0;
                end else if (in_data) begin
                    if (cnt > 0) begin
                        hready = 1'b0; cnt--;
                    end else if (dp_err) begin
                        hresp = 1'b1; hready = err_stage; err_stage = 1'b1;
                    end else begin
                        hready = 1'b1; hrdata = rd_value;
                    end
                    if (hready && cur.write)
                        check_output("dphase_hwdata", 64'(hwdata), 64'(cur.wdata));
                end else begin
                    hready = 1'b1;
                end
                last_addr  = (htrans == 2'b10);
                seen_addr  = haddr; seen_write = hwrite; seen_size = hsize;
                last_ready = hready;
            end
        end
    endtask

    initial begin
        logic [SR_W-1:0]   cap;
        logic [ADDR_W-1:0] wrap_addr;
        int                cyc;
        int                n0;

        nRST = 1'b0; ap_sel = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0;
        update_dr = 1'b0; tdi = 1'b0;
        fork
            slave_loop();
        join_none

        // Reset state
        repeat (3) @(negedge CLK);
        check_output("rst_tdo", 64'(tdo), 64'(0));
        check_output("rst_htrans", 64'(htrans), 64'(0));
        check_output("rst_haddr", 64'(haddr), 64'(0));
        check_output("rst_hwrite", 64'(hwrite), 64'(0));
        check_output("rst_hsize", 64'(hsize), 64'(0));
        check_output("rst_hwdata", 64'(hwdata), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        nRST = 1'b1;
        apply_stimulus('0, 0, cap);
        check_output("rst_capture", 64'(cap), 64'({32'h0, 5'b00001}));

        $display("[TB] test 1: address + write");
        apply_stimulus(mk(32'h2000_0000, 1'b0, 2'b10, 1'b1, 1'b1), 1, cap);
        check_output("t1_addr_frame_no_xfer", 64'(busy), 64'(0));
        expect_xfer(32'h2000_0000, 1'b1, 3'b010, 32'hDEAD_BEEF);
        apply_stimulus(mk(32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 1'b1), 1, cap);
        wait_idle(cyc);
        check_output("t1_busy_cycles", 64'(cyc), 64'(2));
        check_output("t1_nonseq_count", 64'(nonseq_count), 64'(1));

        $display("[TB] test 2: read with wait states");
        wait_states = 2; rd_value = 32'hCAFE_F00D;
        expect_xfer(32'h2000_0004, 1'b0, 3'b010, '0);
        apply_stimulus(mk(32'h0, 1'b1, 2'b10, 1'b0, 1'b0), 1, cap);
        wait_idle(cyc);
        check_output("t2_busy_cycles", 64'(cyc), 64'(4));
        wait_states = 0;
        apply_stimulus('0, 0, cap);
        check_output("t2_rdata", 64'(cap[SR_W-1:5]), 64'(32'hCAFE_F00D));
        check_output("t2_status", 64'(cap[4:0]), 64'(5'b00001));

        $display("[TB] test 3: overrun while stalled");
        apply_stimulus(mk(32'h3000_0000, 1'b0, 2'b10, 1'b0, 1'b1), 1, cap);
        stall = 1'b1;
        expect_xfer(32'h3000_0000, 1'b1, 3'b010, 32'h1111_1111);
        apply_stimulus(mk(32'h1111_1111, 1'b1, 2'b10, 1'b0, 1'b1), 1, cap);
        apply_stimulus(mk(32'h2222_2222, 1'b1, 2'b10, 1'b0, 1'b1), 1, cap);
        apply_stimulus('0, 0, cap);
        check_output("t3_status_stalled", 64'(cap[4:0]), 64'(5'b10101));
        check_output("t3_htrans_held", 64'(htrans), 64'(2'b10));
        check_output("t3_haddr_held", 64'(haddr), 64'(32'h3000_0000));
        check_output("t3_no_second_nonseq", 64'(nonseq_count), 64'(2));
        stall = 1'b0;
        wait_idle(cyc);
        apply_stimulus('0, 0, cap);
        check_output("t3_ovr_sticky", 64'(cap[4:0]), 64'(5'b00101));
        apply_stimulus(mk(32'h3000_0000, 1'b0, 2'b10, 1'b0, 1'b1), 1, cap);
        apply_stimulus('0, 0, cap);
        check_output("t3_ovr_cleared", 64'(cap[4:0]), 64'(5'b00001));
        check_output("t3_nonseq_count", 64'(nonseq_count), 64'(3));

        $display("[TB] test 4: ERROR response");
        apply_stimulus(mk(32'h4000_0000, 1'b0, 2'b10, 1'b1, 1'b1), 1, cap);
        err_next = 1'b1;
        expect_xfer(32'h4000_0000, 1'b1, 3'b010, 32'h55AA_55AA);
        apply_stimulus(mk(32'h55AA_55AA, 1'b1, 2'b10, 1'b0, 1'b1), 1, cap);
        wait_idle(cyc);
        check_output("t4_busy_cycles", 64'(cyc), 64'(3));
        err_next = 1'b0;
        apply_stimulus('0, 0, cap);
        check_output("t4_status_err", 64'(cap[4:0]), 64'(5'b01001));
        check_output("t4_rdata_kept", 64'(cap[SR_W-1:5]), 64'(32'hCAFE_F00D));
        rd_value = 32'h1234_5678;
        expect_xfer(32'h4000_0000, 1'b0, 3'b010, '0);
        apply_stimulus(mk(32'h0, 1'b1, 2'b10, 1'b0, 1'b0), 1, cap);
        wait_idle(cyc);
        apply_stimulus('0, 0, cap);
        check_output("t4_read_after_err", 64'(cap[SR_W-1:5]), 64'(32'h1234_5678));
        check_output("t4_err_still_set", 64'(cap[4:0]), 64'(5'b01001));

        $display("[TB] test 5: 1 KB boundary");
`ifdef AHB_AP_WRAP_1K_EN
        wrap_addr = 32'h0000_0000;
`else
        wrap_addr = 32'h0000_0400;
`endif
        apply_stimulus(mk(32'h0000_03FE, 1'b0, 2'b01, 1'b1, 1'b1), 1, cap);
        expect_xfer(32'h0000_03FE, 1'b1, 3'b001, 32'h0000_AAAA);
        apply_stimulus(mk(32'h0000_AAAA, 1'b1, 2'b01, 1'b0, 1'b1), 1, cap);
        wait_idle(cyc);
        expect_xfer(wrap_addr, 1'b0, 3'b001, '0);
        apply_stimulus(mk(32'h0, 1'b1, 2'b01, 1'b0, 1'b0), 1, cap);
        wait_idle(cyc);

        $display("[TB] test 6: reserved size, ap_sel low, reset mid-transfer");
        apply_stimulus('0, 0, cap);
        check_output("t6_status_clean", 64'(cap[4:0]), 64'(5'b00001));
        n0 = nonseq_count;
        apply_stimulus(mk(32'h0000_0077, 1'b1, 2'b11, 1'b0, 1'b1), 1, cap);
        repeat (3) @(negedge CLK);
        check_output("t6_rsvd_no_busy", 64'(busy), 64'(0));
        check_output("t6_rsvd_no_nonseq", 64'(nonseq_count), 64'(n0));
        apply_stimulus('0, 0, cap);
        check_output("t6_rsvd_err", 64'(cap[4:0]), 64'(5'b01001));
        apply_stimulus(mk(32'h0000_0099, 1'b1, 2'b10, 1'b0, 1'b1), 0, cap);
        ap_sel = 1'b0;
        @(negedge CLK); update_dr = 1'b1;
        @(negedge CLK); update_dr = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("t6_apsel_ignored", 64'(nonseq_count), 64'(n0));
        ap_sel = 1'b1;
        apply_stimulus(mk(32'h5000_0000, 1'b0, 2'b10, 1'b0, 1'b1), 1, cap);
        wait_states = 5;
        expect_xfer(32'h5000_0000, 1'b1, 3'b010, 32'h0000_0066);
        apply_stimulus(mk(32'h0000_0066, 1'b1, 2'b10, 1'b0, 1'b1), 1, cap);
        repeat (2) @(negedge CLK);
        check_output("t6_busy_in_data", 64'(busy), 64'(1));
        nRST = 1'b0;
        #1;
        check_output("t6_rst_htrans", 64'(htrans), 64'(0));
        check_output("t6_rst_haddr", 64'(haddr), 64'(0));
        check_output("t6_rst_hwrite", 64'(hwrite), 64'(0));
        check_output("t6_rst_hsize", 64'(hsize), 64'(0));
        check_output("t6_rst_hwdata", 64'(hwdata), 64'(0));
        check_output("t6_rst_busy", 64'(busy), 64'(0));
        check_output("t6_rst_tdo", 64'(tdo), 64'(0));
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        wait_states = 0;
        apply_stimulus('0, 0, cap);
        check_output("t6_post_rst_capture", 64'(cap), 64'({32'h0, 5'b00001}));
        check_output("sb_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
